vc_demux_ctrl: RTL and testbench

VC_DEMUX_CTRL -- requirements
Module: vc_demux_ctrl

---
 rtl/vc_ctrl_pkg.sv | 24 ++
 rtl/vc_demux_ctrl_if.sv | 40 ++++
 rtl/vc_demux_ctrl.sv | 155 +++++++++++++++
 tb/tb_vc_demux_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vc_ctrl_pkg.sv
// Shared definitions for the virtual-channel demux controller:
// FSM state codes, default widths and the head-of-line blocking helper.
package vc_ctrl_pkg;

    localparam int DEF_DATA_SIZE = 6;
    localparam int DEF_TH_W      = 3;
    localparam int DEF_CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // The head word is stuck when its own destination VC is almost full.
    function automatic logic route_blocked(input logic sel,
                                           input logic vc0_af,
                                           input logic vc1_af);
        return sel ? vc1_af : vc0_af;
    endfunction

endpackage

// File: rtl/vc_demux_ctrl_if.sv
// Source-FIFO / destination-VC handshake bundle seen by the demux controller.
// master = controller side, slave = FIFO/demux datapath side.
interface vc_demux_ctrl_if
    import vc_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
) ();

    logic                 src_empty;
    logic [DATA_SIZE-1:0] src_data;
    logic                 vc0_almost_full;
    logic                 vc1_almost_full;
    logic                 vc0_empty;
    logic                 vc1_empty;
    logic                 en_pop;
    logic                 selector;

    modport master (
        input  src_empty,
        input  src_data,
        input  vc0_almost_full,
        input  vc1_almost_full,
        input  vc0_empty,
        input  vc1_empty,
        output en_pop,
        output selector
    );

    modport slave (
        output src_empty,
        output src_data,
        output vc0_almost_full,
        output vc1_almost_full,
        output vc0_empty,
        output vc1_empty,
        input  en_pop,
        input  selector
    );

endinterface

// File: rtl/vc_demux_ctrl.sv
// Controller that pops a first-word-fall-through source FIFO into two VC FIFOs,
// distributes thresholds, counts routed words and latches FIFO errors.
module vc_demux_ctrl
    import vc_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int TH_W      = DEF_TH_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [TH_W-1:0]  umbral_alto,
    input  logic [TH_W-1:0]  umbral_bajo,
    input  logic             fifo_error,
    vc_demux_ctrl_if.master  bus,
    output logic [TH_W-1:0]  umbral_alto_out,
    output logic [TH_W-1:0]  umbral_bajo_out,
    output logic [2:0]       state,
    output logic             idle,
    output logic             error_out,
    output logic [CNT_W-1:0] cnt_vc0,
    output logic [CNT_W-1:0] cnt_vc1
);

    logic [2:0]      state_r;
    logic [2:0]      next_state_s;
    logic            en_pop_s;
    logic            idle_s;
    logic            error_s;
    logic            sel_s;
    logic [TH_W-1:0] th_alto_r;
    logic [TH_W-1:0] th_bajo_r;
    logic [CNT_W-1:0] cnt_vc0_r;
    logic [CNT_W-1:0] cnt_vc1_r;

    // The route bit is the MSB of the head word, valid whenever the FIFO is non-empty.
    assign sel_s = bus.src_data[DATA_SIZE-1];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; fifo_error outranks init, which outranks the data-driven moves.
    always_comb begin
        next_state_s = ST_RESET;
        case (state_r)
            ST_RESET: begin
                next_state_s = ST_INIT;
            end
            ST_INIT: begin
                if (fifo_error) begin
                    next_state_s = ST_ERROR;
                end else if (init) begin
                    next_state_s = ST_INIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (fifo_error) begin
                    next_state_s = ST_ERROR;
                end else if (init) begin
                    next_state_s = ST_INIT;
                end else if (!bus.src_empty) begin
                    next_state_s = ST_ACTIVE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (fifo_error) begin
                    next_state_s = ST_ERROR;
                end else if (init) begin
                    next_state_s = ST_INIT;
                end else if (bus.src_empty) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                next_state_s = ST_ERROR;
            end
            default: begin
                next_state_s = ST_RESET;
            end
        endcase
    end

    // Output decode; popping depends on the current state only, so the exit cycle still pops.
    always_comb begin
        en_pop_s = 1'b0;
        idle_s   = 1'b0;
        error_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                idle_s = bus.src_empty & bus.vc0_empty & bus.vc1_empty;
            end
            ST_ACTIVE: begin
                if (!bus.src_empty && !route_blocked(sel_s, bus.vc0_almost_full,
                                                     bus.vc1_almost_full)) begin
                    en_pop_s = 1'b1;
                end else begin
                    en_pop_s = 1'b0;
                end
            end
            ST_ERROR: begin
                error_s = 1'b1;
            end
            default: begin
                en_pop_s = 1'b0;
            end
        endcase
    end

    // Threshold distribution and per-VC transfer counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            th_alto_r <= '0;
            th_bajo_r <= '0;
            cnt_vc0_r <= '0;
            cnt_vc1_r <= '0;
        end else if (state_r == ST_INIT) begin
            th_alto_r <= umbral_alto;
            th_bajo_r <= umbral_bajo;
            cnt_vc0_r <= '0;
            cnt_vc1_r <= '0;
        end else if (en_pop_s) begin
            if (sel_s) begin
                cnt_vc1_r <= cnt_vc1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_vc0_r <= cnt_vc0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            th_alto_r <= th_alto_r;
        end
    end

    assign bus.en_pop      = en_pop_s;
    assign bus.selector    = sel_s;
    assign umbral_alto_out = th_alto_r;
    assign umbral_bajo_out = th_bajo_r;
    assign state           = state_r;
    assign idle            = idle_s;
    assign error_out       = error_s;
    assign cnt_vc0         = cnt_vc0_r;
    assign cnt_vc1         = cnt_vc1_r;

endmodule

// File: tb/tb_vc_demux_ctrl.sv
// Directed bench for vc_demux_ctrl: init, routing, head-of-line blocking,
// counter wrap, init re-entry, sticky error and mid-stream reset.
module tb_vc_demux_ctrl;
    import vc_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       init;
    logic [2:0] umbral_alto;
    logic [2:0] umbral_bajo;
    logic       fifo_error;
    logic [2:0] umbral_alto_out;
    logic [2:0] umbral_bajo_out;
    logic [2:0] state;
    logic       idle;
    logic       error_out;
    logic [7:0] cnt_vc0;
    logic [7:0] cnt_vc1;

    int errors;
    int checks;

    vc_demux_ctrl_if #(.DATA_SIZE(6)) bus ();

    vc_demux_ctrl #(.DATA_SIZE(6), .TH_W(3), .CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_alto     (umbral_alto),
        .umbral_bajo     (umbral_bajo),
        .fifo_error      (fifo_error),
        .bus             (bus),
        .umbral_alto_out (umbral_alto_out),
        .umbral_bajo_out (umbral_bajo_out),
        .state           (state),
        .idle            (idle),
        .error_out       (error_out),
        .cnt_vc0         (cnt_vc0),
        .cnt_vc1         (cnt_vc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0; fifo_error = 1'b0;
        umbral_alto = 3'd0; umbral_bajo = 3'd0;
        bus.src_empty = 1'b1; bus.src_data = 6'h00;
        bus.vc0_almost_full = 1'b0; bus.vc1_almost_full = 1'b0;
        bus.vc0_empty = 1'b1; bus.vc1_empty = 1'b1;
        tick(); tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (umbral_alto_out !== 3'd0 || umbral_bajo_out !== 3'd0) begin errors++; $display("FAIL reset_thresholds: got %0d/%0d expected 0/0", umbral_alto_out, umbral_bajo_out); end
        checks++; if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cnt_vc0, cnt_vc1); end
        checks++; if (bus.en_pop !== 1'b0 || idle !== 1'b0 || error_out !== 1'b0) begin errors++; $display("FAIL reset_flags: got en_pop=%0b idle=%0b err=%0b expected 0/0/0", bus.en_pop, idle, error_out); end
    endtask

    task automatic test_init();
        reset = 1'b0; init = 1'b1; umbral_alto = 3'd6; umbral_bajo = 3'd1;
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL init_enter: got %0d expected 1", state); end
        tick();
        checks++; if (umbral_alto_out !== 3'd6 || umbral_bajo_out !== 3'd1) begin errors++; $display("FAIL init_load: got %0d/%0d expected 6/1", umbral_alto_out, umbral_bajo_out); end
        init = 1'b0;
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL init_to_idle: got %0d expected 2", state); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_drained: got %0b expected 1", idle); end
        umbral_alto = 3'd3; umbral_bajo = 3'd2;
        tick();
        checks++; if (umbral_alto_out !== 3'd6 || umbral_bajo_out !== 3'd1) begin errors++; $display("FAIL threshold_hold: got %0d/%0d expected 6/1", umbral_alto_out, umbral_bajo_out); end
    endtask

    task automatic test_route();
        bus.vc0_empty = 1'b0;
        #1;
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL idle_vc0_busy: got %0b expected 0", idle); end
        bus.vc0_empty = 1'b1;
        bus.src_empty = 1'b0; bus.src_data = 6'h25;
        #1;
        checks++; if (bus.selector !== 1'b1 || bus.en_pop !== 1'b0) begin errors++; $display("FAIL idle_no_pop: got sel=%0b en_pop=%0b expected 1/0", bus.selector, bus.en_pop); end
        tick();
        checks++; if (state !== 3'd3 || bus.en_pop !== 1'b1) begin errors++; $display("FAIL active_pop_vc1: got state=%0d en_pop=%0b expected 3/1", state, bus.en_pop); end
        tick();
        checks++; if (cnt_vc1 !== 8'd1 || cnt_vc0 !== 8'd0) begin errors++; $display("FAIL count_vc1: got %0d/%0d expected vc0=0 vc1=1", cnt_vc0, cnt_vc1); end
        bus.src_data = 6'h05;
        #1;
        checks++; if (bus.selector !== 1'b0 || bus.en_pop !== 1'b1) begin errors++; $display("FAIL active_pop_vc0: got sel=%0b en_pop=%0b expected 0/1", bus.selector, bus.en_pop); end
        tick();
        checks++; if (cnt_vc0 !== 8'd1 || cnt_vc1 !== 8'd1) begin errors++; $display("FAIL count_vc0: got %0d/%0d expected 1/1", cnt_vc0, cnt_vc1); end
        bus.src_empty = 1'b1;
        #1;
        checks++; if (bus.en_pop !== 1'b0) begin errors++; $display("FAIL empty_no_pop: got %0b expected 0", bus.en_pop); end
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL active_to_idle: got %0d expected 2", state); end
    endtask

    task automatic test_head_of_line();
        bus.src_empty = 1'b0; bus.src_data = 6'h05; bus.vc0_almost_full = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.en_pop !== 1'b0) begin errors++; $display("FAIL hol_blocked_%0d: got en_pop=%0b expected 0", i, bus.en_pop); end
            tick();
        end
        checks++; if (cnt_vc0 !== 8'd1 || cnt_vc1 !== 8'd1) begin errors++; $display("FAIL hol_no_count: got %0d/%0d expected 1/1", cnt_vc0, cnt_vc1); end
        bus.vc0_almost_full = 1'b0;
        #1;
        checks++; if (bus.en_pop !== 1'b1) begin errors++; $display("FAIL hol_release: got %0b expected 1", bus.en_pop); end
        tick();
        bus.src_data = 6'h25; bus.vc1_almost_full = 1'b1;
        #1;
        checks++; if (bus.en_pop !== 1'b0) begin errors++; $display("FAIL vc1_blocked: got %0b expected 0", bus.en_pop); end
        bus.vc1_almost_full = 1'b0;
        tick();
        checks++; if (cnt_vc0 !== 8'd2 || cnt_vc1 !== 8'd2) begin errors++; $display("FAIL hol_counts: got %0d/%0d expected 2/2", cnt_vc0, cnt_vc1); end
        bus.src_empty = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        bus.src_empty = 1'b0; bus.src_data = 6'h05;
        tick();
        repeat (253) tick();
        checks++; if (cnt_vc0 !== 8'd255) begin errors++; $display("FAIL wrap_pre: got %0d expected 255", cnt_vc0); end
        tick();
        checks++; if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd2) begin errors++; $display("FAIL wrap_zero: got %0d/%0d expected 0/2", cnt_vc0, cnt_vc1); end
    endtask

    task automatic test_init_reentry();
        bus.src_empty = 1'b1; init = 1'b1;
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL reinit_enter: got %0d expected 1", state); end
        umbral_alto = 3'd5; umbral_bajo = 3'd2;
        tick();
        checks++; if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin errors++; $display("FAIL reinit_clear: got %0d/%0d expected 0/0", cnt_vc0, cnt_vc1); end
        checks++; if (umbral_alto_out !== 3'd5 || umbral_bajo_out !== 3'd2) begin errors++; $display("FAIL reinit_load: got %0d/%0d expected 5/2", umbral_alto_out, umbral_bajo_out); end
        init = 1'b0;
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL reinit_idle: got %0d expected 2", state); end
    endtask

    task automatic test_error();
        bus.src_empty = 1'b0; bus.src_data = 6'h05;
        tick();
        fifo_error = 1'b1; init = 1'b1;
        tick();
        checks++; if (state !== 3'd4 || error_out !== 1'b1 || bus.en_pop !== 1'b0) begin errors++; $display("FAIL error_enter: got state=%0d err=%0b en_pop=%0b expected 4/1/0", state, error_out, bus.en_pop); end
        fifo_error = 1'b0; init = 1'b0;
        tick(); tick();
        checks++; if (state !== 3'd4 || error_out !== 1'b1 || bus.en_pop !== 1'b0) begin errors++; $display("FAIL error_sticky: got state=%0d err=%0b en_pop=%0b expected 4/1/0", state, error_out, bus.en_pop); end
        reset = 1'b1;
        tick();
        checks++; if (state !== 3'd0 || error_out !== 1'b0) begin errors++; $display("FAIL error_reset: got state=%0d err=%0b expected 0/0", state, error_out); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0; init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        tick();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL mid_active: got %0d expected 3", state); end
        tick();
        checks++; if (cnt_vc0 !== 8'd1 || bus.en_pop !== 1'b1) begin errors++; $display("FAIL mid_stream: got cnt=%0d en_pop=%0b expected 1/1", cnt_vc0, bus.en_pop); end
        reset = 1'b1;
        tick();
        checks++; if (state !== 3'd0 || cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin errors++; $display("FAIL mid_reset: got state=%0d cnt=%0d/%0d expected 0/0/0", state, cnt_vc0, cnt_vc1); end
        checks++; if (bus.en_pop !== 1'b0 || idle !== 1'b0 || umbral_alto_out !== 3'd0) begin errors++; $display("FAIL mid_reset_outs: got en_pop=%0b idle=%0b alto=%0d expected 0/0/0", bus.en_pop, idle, umbral_alto_out); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_init();
        test_route();
        test_head_of_line();
        test_wrap();
        test_init_reentry();
        test_error();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
